uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Synthesizable, parametrised UART receiver with a built-in receive FIFO. It is the RTL successor to the bench-side serial monitor: the same mid-bit sampling scheme, generalised to a run-time baud divider, 5–9 data bits, optional parity and 1/2 stop bits. It adds false-start rejection, framing/parity/overflow detection and a ready/valid read port. It sits between the board `ser_rx` pin and the SoC bus glue, beside the flash controller.

## Interface
Parameters:
- `DATA_BITS`, 8: data bits per frame, legal 5..9, sent LSB first.
- `PARITY`, 0: parity mode; 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1: stop bits, 1 or 2.
- `FIFO_DEPTH`, 16: number of entries, power of two, at least 2.
- `DIV_WIDTH`, 16: width of `cfg_div`.

Ports:
- `clk` in 1: single clock.
- `resetn` in 1: reset, asynchronous assert, active-low.
- `cfg_div` in DIV_WIDTH: clocks per bit, legal ≥ 4; sampled at each start-edge detect.
- `rx` in 1: serial line, asynchronous; idles high.
- `rd_valid` out 1: FIFO not empty.
- `rd_ready` in 1: pop when asserted together with `rd_valid`.
- `rd_data` out DATA_BITS: head entry data.
- `rd_frame_err` out 1: head entry had a stop bit of 0.
- `rd_parity_err` out 1: head entry failed the parity check.
- `overflow` out 1: sticky; a frame was dropped because the FIFO was full.
- `clr_overflow` in 1: clears `overflow`.
- `level` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `busy` out 1: receiver FSM is not in IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser, then a registered copy. Edge detect fires when the synchroniser output is 0 and the registered copy is 1.
- **IDLE:** on edge detect, latch `cfg_div` into `div_q`, load bit counter with `div_q>>1`, go to START.
- **START:** when the counter expires, sample the line.
  - Line = 1: false start; return to IDLE with no push.
  - Line = 0: go to DATA with the counter reloaded to `div_q`.
- **DATA:** sample once per `div_q` clocks; shift the sample into the MSB of the shift register (LSB-first assembly). After `DATA_BITS` samples, go to PAR if PARITY≠0, else STOP.
- **PAR:** one sample. Error when the XOR of data and the parity bit is 0 for odd mode, or 1 for even mode.
- **STOP:** `STOP_BITS` samples. Any sample of 0 sets the frame error. On the last sample, push {data, frame_err, parity_err} and return to IDLE.
  - If the frame error is set and the line is still 0 (break), go to BREAK instead.
- **BREAK:** wait for the synchronised line = 1, then go to IDLE. No further pushes during a break.
- Push while full (with no simultaneous pop): the frame is discarded and `overflow` is set. A push and a pop in the same cycle while full both succeed.
- `clr_overflow` asserted in the same cycle as a new overflow: `overflow` ends set (set wins).
- FIFO: circular buffer with (log2 DEPTH + 1)-bit read and write pointers; pointers wrap naturally. `rd_*` outputs show the head entry combinationally from the registered read pointer.

## Timing
- Let T be the edge-detect cycle. This is 2–3 clocks after the `rx` falling edge.
- Start sample at T+floor(div/2).
- Data bit i sampled at T+floor(div/2)+(i+1)·div.
- Last stop sample at T+floor(div/2)+(DATA_BITS+P+STOP_BITS)·div, where P = 1 if PARITY≠0, else 0.
- `rd_valid` and `level` update the cycle after the push.
- A pop takes effect at the clock edge where `rd_valid && rd_ready`; the next entry is presented the following cycle.
- Back-to-back frames: the next edge is accepted from the cycle after the last stop sample (IDLE is re-entered at that edge).
- Reset values: `rd_valid`=0, `level`=0, `overflow`=0, `busy`=0, `rd_data`=0, `rd_frame_err`=0, `rd_parity_err`=0. Synchroniser flops reset to 1.
- Reset mid-frame aborts the frame; the partial frame is never pushed.

## Structure
- Package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, PAR, STOP, BREAK).
  - Parity mode constants (`PAR_NONE`, `PAR_ODD`, `PAR_EVEN`).
- One sub-module, `sync_fifo`, parametrised on width and depth, with `full`, `empty` and `level` outputs. The receiver FSM, counters and synchroniser live in `uart_rx_fifo`.

## Test plan
- `cfg_div`=8, 8N1, send 0x55 → single entry 0x55 with both error flags 0; `rd_valid` at T+77.
- Low pulse of 3 clocks on `rx` with `cfg_div`=8 → no push; `busy` returns to 0 at T+4.
- PARITY=2, send 0xA5 with parity bit 1 → `rd_parity_err`=1; with parity bit 0 → `rd_parity_err`=0.
- Send 0x3C with stop bit 0, then hold `rx` low for 40 clocks → one entry 0x3C with `rd_frame_err`=1; no further entries until `rx` returns high.
- FIFO_DEPTH=4, `rd_ready`=0, send 5 frames (0x01..0x05) → `level`=4, `overflow`=1, and pops return 0x01..0x04. Pulse `clr_overflow` → `overflow`=0.
- Assert `resetn`=0 mid-DATA → all outputs at reset values; after release, the next clean 0x7E frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and parity modes.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4,
        BREAK = 3'd5
    } rx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // data_xor is the XOR of all data bits; odd mode wants the total (data+parity) odd.
    function automatic logic parity_error(input logic data_xor, input logic par_bit, input int mode);
        logic w_sum;
        w_sum = data_xor ^ par_bit;
        if (mode == PAR_ODD)
            return ~w_sum;
        else if (mode == PAR_EVEN)
            return w_sum;
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with extra-MSB pointers; head is shown combinationally.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_rd;
    logic             w_wr;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign level = r_wr_ptr - r_rd_ptr;

    // A write while full is accepted only when a pop frees the head slot in the same cycle.
    assign w_rd = rd_en & ~empty;
    assign w_wr = wr_en & (~full | w_rd);

    assign rd_data = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with mid-bit sampling, run-time baud divider, error flags and receive FIFO.
// state | meaning
// IDLE  | waiting for a falling edge on the synchronised line
// START | half-bit wait, then confirm the start bit is still low
// DATA  | sampling DATA_BITS data bits, LSB first
// PAR   | sampling the parity bit
// STOP  | sampling STOP_BITS stop bits, pushing the frame on the last one
// BREAK | line held low after a framing error; wait for it to return high
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [DIV_WIDTH-1:0]          cfg_div,
    input  logic                          rx,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_frame_err,
    output logic                          rd_parity_err,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy
);

    localparam int          EW        = DATA_BITS + 2;
    localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);

    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_rx_q;
    rx_state_e              r_state;
    logic [DIV_WIDTH-1:0]   r_div;
    logic [DIV_WIDTH-1:0]   r_cnt;
    logic [3:0]             r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_ferr;
    logic                   r_perr;
    logic                   r_overflow;

    logic                   w_edge;
    logic                   w_tick;
    logic                   w_sample;
    logic                   w_ferr_next;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [EW-1:0]          w_wr_entry;
    logic [EW-1:0]          w_rd_entry;

    assign w_sample    = r_sync2;
    assign w_edge      = ~r_sync2 & r_rx_q;
    assign w_tick      = (r_cnt == DIV_WIDTH'(1));
    assign w_ferr_next = r_ferr | ~w_sample;
    assign w_push      = (r_state == STOP) && w_tick && (r_bit_cnt == LAST_STOP);
    assign w_pop       = rd_valid & rd_ready;
    assign w_wr_entry  = {r_shift, w_ferr_next, r_perr};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_rx_q  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_rx_q  <= r_sync2;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_div     <= '0;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_ferr    <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            if (r_state != IDLE && r_state != BREAK && !w_tick)
                r_cnt <= r_cnt - 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_edge) begin
                        r_div   <= cfg_div;
                        r_cnt   <= cfg_div >> 1;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (w_sample) begin
                            r_state <= IDLE;
                        end else begin
                            r_cnt     <= r_div;
                            r_bit_cnt <= '0;
                            r_ferr    <= 1'b0;
                            r_perr    <= 1'b0;
                            r_state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shift <= {w_sample, r_shift[DATA_BITS-1:1]};
                        r_cnt   <= r_div;
                        if (r_bit_cnt == LAST_DATA) begin
                            r_bit_cnt <= '0;
                            r_state   <= (PARITY != PAR_NONE) ? PAR : STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                end
                PAR: begin
                    if (w_tick) begin
                        r_perr  <= parity_error(^r_shift, w_sample, PARITY);
                        r_cnt   <= r_div;
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_ferr <= w_ferr_next;
                        r_cnt  <= r_div;
                        if (r_bit_cnt == LAST_STOP) begin
                            r_bit_cnt <= '0;
                            r_state   <= (w_ferr_next && !w_sample) ? BREAK : IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                end
                BREAK: begin
                    if (w_sample)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Set wins over clear so an overflow in the clearing cycle is never lost.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_overflow <= 1'b0;
        else if (w_push && w_full && !w_pop)
            r_overflow <= 1'b1;
        else if (clr_overflow)
            r_overflow <= 1'b0;
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (w_push),
        .wr_data (w_wr_entry),
        .rd_en   (rd_ready),
        .rd_data (w_rd_entry),
        .full    (w_full),
        .empty   (w_empty),
        .level   (level)
    );

    assign rd_valid      = ~w_empty;
    assign rd_data       = w_rd_entry[EW-1:2];
    assign rd_frame_err  = w_rd_entry[1];
    assign rd_parity_err = w_rd_entry[0];
    assign overflow      = r_overflow;
    assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo (8E1, 4-deep FIFO): serial stimulus, queued expectations, pop monitor.
module tb_uart_rx_fifo;

    localparam int DB = 8;
    localparam int PB = 2;
    localparam int SB = 1;
    localparam int FD = 4;
    localparam int DW = 16;

    logic           clk = 1'b0;
    logic           resetn;
    logic [DW-1:0]  cfg_div;
    logic           rx;
    logic           rd_valid;
    logic           rd_ready;
    logic [DB-1:0]  rd_data;
    logic           rd_frame_err;
    logic           rd_parity_err;
    logic           overflow;
    logic           clr_overflow;
    logic [2:0]     level;
    logic           busy;

    int             total = 0;
    int             bad   = 0;
    int             rd_mode = 0;
    logic [9:0]     exp_q[$];

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DATA_BITS  (DB),
        .PARITY     (PB),
        .STOP_BITS  (SB),
        .FIFO_DEPTH (FD),
        .DIV_WIDTH  (DW)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .cfg_div       (cfg_div),
        .rx            (rx),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .rd_frame_err  (rd_frame_err),
        .rd_parity_err (rd_parity_err),
        .overflow      (overflow),
        .clr_overflow  (clr_overflow),
        .level         (level),
        .busy          (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Even parity: the data ones plus the parity bit should be even; anything else is an error.
    function automatic logic [9:0] make_exp(input logic [7:0] data, input logic pb, input logic sb);
        int ones;
        ones = $countones(data) + int'(pb);
        return {data, ~sb, logic'(ones % 2)};
    endfunction

    task automatic drive_bit(input logic b, input int d);
        rx = b;
        repeat (d) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic pb, input logic sb, input int d);
        cfg_div = DW'(d);
        drive_bit(1'b0, d);
        for (int i = 0; i < 8; i++)
            drive_bit(data[i], d);
        drive_bit(pb, d);
        drive_bit(sb, d);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rd_valid) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rd_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rd_mode)
                0:       rd_ready = 1'b0;
                1:       rd_ready = 1'b1;
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (resetn && rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_entry: got %0h/%0b/%0b required none",
                             rd_data, rd_frame_err, rd_parity_err);
                end else begin
                    e = exp_q.pop_front();
                    check("entry_data", 32'(rd_data), 32'(e[9:2]));
                    check("entry_frame_err", 32'(rd_frame_err), 32'(e[1]));
                    check("entry_parity_err", 32'(rd_parity_err), 32'(e[0]));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish required finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [7:0] d8;
        logic       pb;
        logic       sb;
        int         d;
        int         n;

        resetn       = 1'b0;
        rx           = 1'b1;
        clr_overflow = 1'b0;
        cfg_div      = DW'(8);
        repeat (4) @(posedge clk);
        #1;
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_frame_err", 32'(rd_frame_err), 32'd0);
        check("rst_parity_err", 32'(rd_parity_err), 32'd0);
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Latency of a clean frame: push lands after the stop sample.
        rd_mode = 0;
        d8 = 8'h55;
        pb = ^d8;
        exp_q.push_back(make_exp(d8, pb, 1'b1));
        fork
            send_frame(d8, pb, 1'b1, 8);
            begin
                n = 0;
                while (!rd_valid && n < 400) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check("valid_latency", 32'(n), 32'(3 + 8 / 2 + 10 * 8));
                check("level_one", 32'(level), 32'd1);
            end
        join
        rd_mode = 1;
        wait_drain("clean");

        // Parity good and bad.
        d8 = 8'hA5;
        exp_q.push_back(make_exp(d8, 1'b1, 1'b1));
        send_frame(d8, 1'b1, 1'b1, 8);
        exp_q.push_back(make_exp(d8, 1'b0, 1'b1));
        send_frame(d8, 1'b0, 1'b1, 8);
        drive_bit(1'b1, 8);
        wait_drain("parity");

        // False start: 3-clock glitch.
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("glitch_busy", 32'(busy), 32'd1);
        rx = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("glitch_idle", 32'(busy), 32'd0);
        check("glitch_level", 32'(level), 32'd0);

        // Break after a framing error.
        rd_mode = 0;
        d8 = 8'h3C;
        pb = ^d8;
        exp_q.push_back(make_exp(d8, pb, 1'b0));
        send_frame(d8, pb, 1'b0, 8);
        repeat (40) @(posedge clk);
        #1;
        check("break_busy", 32'(busy), 32'd1);
        check("break_level", 32'(level), 32'd1);
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("break_exit", 32'(busy), 32'd0);
        check("break_level_after", 32'(level), 32'd1);
        rd_mode = 1;
        wait_drain("break");

        // Overflow: five frames into a four-deep FIFO with no reads.
        rd_mode = 0;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 5; i++) begin
            d8 = 8'(i);
            pb = ^d8;
            if (i <= FD)
                exp_q.push_back(make_exp(d8, pb, 1'b1));
            send_frame(d8, pb, 1'b1, 8);
        end
        repeat (4) @(posedge clk);
        #1;
        check("ovf_level", 32'(level), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        @(posedge clk);
        #1;
        clr_overflow = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        rd_mode = 1;
        wait_drain("overflow");
        check("ovf_level_drained", 32'(level), 32'd0);

        // Randomised frames with random reader back-pressure.
        rd_mode = 2;
        for (int i = 0; i < 16; i++) begin
            d  = $urandom_range(6, 16);
            d8 = 8'($urandom_range(0, 255));
            pb = (^d8) ^ ($urandom_range(0, 4) == 0);
            sb = ($urandom_range(0, 5) != 0);
            exp_q.push_back(make_exp(d8, pb, sb));
            send_frame(d8, pb, sb, d);
            if (!sb || $urandom_range(0, 1) == 1)
                drive_bit(1'b1, d);
        end
        drive_bit(1'b1, 16);
        wait_drain("random");
        check("random_no_overflow", 32'(overflow), 32'd0);

        // Reset mid-DATA drops both the stored frame and the partial one.
        rd_mode = 0;
        d8 = 8'h11;
        pb = ^d8;
        exp_q.push_back(make_exp(d8, pb, 1'b1));
        send_frame(d8, pb, 1'b1, 8);
        drive_bit(1'b0, 8);
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 4);
        check("pre_reset_level", 32'(level), 32'd1);
        resetn = 1'b0;
        rx = 1'b1;
        exp_q.delete();
        #2;
        check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rd_data", 32'(rd_data), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rd_mode = 1;
        d8 = 8'h7E;
        pb = ^d8;
        exp_q.push_back(make_exp(d8, pb, 1'b1));
        send_frame(d8, pb, 1'b1, 8);
        drive_bit(1'b1, 8);
        wait_drain("post_reset");
        check("final_level", 32'(level), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
